// File: rtl/in_port_packer.sv
// in_port_packer: packs PACK pixels of DSIZE bits (each zero-extended to a PSIZE slot)
// into one write-FIFO word. Words are tagged SOF/EOL/EOF and partial words are flushed
// at line or frame end. A sticky flag records any write issued into a full FIFO.
module in_port_packer #(
    parameter int unsigned DSIZE  = 24,
    parameter int unsigned PSIZE  = 32,
    parameter int unsigned PACK   = 4,
    parameter int unsigned FILL_W = 3
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    falign,
    input  logic                    lalign,
    input  logic                    ealign,
    input  logic                    idata_vld,
    input  logic [DSIZE-1:0]        idata,
    input  logic                    fifo_full,
    output logic                    wr_en,
    output logic [PACK*PSIZE-1:0]   wr_data,
    output logic                    wr_sof,
    output logic                    wr_eol,
    output logic                    wr_eof,
    output logic [FILL_W-1:0]       wr_fill,
    output logic                    overflow
);

    localparam int unsigned CntW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned WordW = PACK * PSIZE;

    // Accumulation state for the word being assembled
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WordW-1:0]  slots_q, slots_d;
    logic              sof_pending_q, sof_pending_d;
    logic              overflow_q, overflow_d;

    // Registered write-side outputs
    logic              wr_en_q, wr_en_d;
    logic [WordW-1:0]  wr_data_q, wr_data_d;
    logic              wr_sof_q, wr_sof_d;
    logic              wr_eol_q, wr_eol_d;
    logic              wr_eof_q, wr_eof_d;
    logic [FILL_W-1:0] wr_fill_q, wr_fill_d;

    // Per-cycle intermediates
    logic [PSIZE-1:0]  pix_ext;
    logic [CntW-1:0]   cnt_base;
    logic [WordW-1:0]  slots_base;
    logic [WordW-1:0]  word;
    logic [FILL_W-1:0] fill;
    logic              line_end;
    logic              sof_eff;
    logic              emit;

    assign pix_ext = PSIZE'(idata);

    // Next-state: fold in the incoming pixel, decide whether a word is emitted this edge
    always_comb begin
        cnt_d         = cnt_q;
        slots_d       = slots_q;
        sof_pending_d = sof_pending_q;
        overflow_d    = overflow_q | (wr_en_q & fifo_full);
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        wr_sof_d      = 1'b0;
        wr_eol_d      = 1'b0;
        wr_eof_d      = 1'b0;
        wr_fill_d     = '0;

        // falign restarts the frame: drop the partial word and treat this cycle as slot 0
        cnt_base   = falign ? '0 : cnt_q;
        slots_base = falign ? '0 : slots_q;
        sof_eff    = falign | sof_pending_q;
        // falign masks line/frame end strobes arriving in the same cycle
        line_end   = ~falign & (lalign | ealign);

        word = slots_base;
        if (idata_vld) begin
            word[int'(cnt_base) * PSIZE +: PSIZE] = pix_ext;
        end
        fill = FILL_W'(cnt_base) + FILL_W'(idata_vld);

        emit = (fill == FILL_W'(PACK)) || (line_end && (fill != '0));

        if (falign) begin
            sof_pending_d = 1'b1;
            overflow_d    = 1'b0;
        end

        if (emit) begin
            wr_en_d       = 1'b1;
            wr_data_d     = word;
            wr_fill_d     = fill;
            wr_sof_d      = sof_eff;
            wr_eol_d      = line_end;
            wr_eof_d      = line_end & ealign;
            sof_pending_d = 1'b0;
            // Emitted word leaves empty slots so unfilled lanes of the next flush read zero
            slots_d       = '0;
            cnt_d         = '0;
        end else begin
            slots_d = word;
            cnt_d   = CntW'(fill);
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            slots_q       <= '0;
            sof_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            wr_sof_q      <= 1'b0;
            wr_eol_q      <= 1'b0;
            wr_eof_q      <= 1'b0;
            wr_fill_q     <= '0;
        end else begin
            cnt_q         <= cnt_d;
            slots_q       <= slots_d;
            sof_pending_q <= sof_pending_d;
            overflow_q    <= overflow_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            wr_sof_q      <= wr_sof_d;
            wr_eol_q      <= wr_eol_d;
            wr_eof_q      <= wr_eof_d;
            wr_fill_q     <= wr_fill_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_data  = wr_data_q;
    assign wr_sof   = wr_sof_q;
    assign wr_eol   = wr_eol_q;
    assign wr_eof   = wr_eof_q;
    assign wr_fill  = wr_fill_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_in_port_packer.sv
// Bench for in_port_packer: directed scenarios followed by random traffic, every cycle
// checked against a queue-based model of the packing rules.
module tb_in_port_packer;

    localparam int unsigned DSIZE  = 24;
    localparam int unsigned PSIZE  = 32;
    localparam int unsigned PACK   = 4;
    localparam int unsigned FILL_W = 3;
    localparam int unsigned W      = PACK * PSIZE;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             falign, lalign, ealign, idata_vld, fifo_full;
    logic [DSIZE-1:0] idata;
    logic             wr_en, wr_sof, wr_eol, wr_eof, overflow;
    logic [W-1:0]     wr_data;
    logic [FILL_W-1:0] wr_fill;

    int checks   = 0;
    int failures = 0;

    // Reference model: pixels of the current word, pending SOF, sticky overflow,
    // and the outputs expected to be visible after the next edge.
    logic [DSIZE-1:0]  cur[$];
    logic              m_sof = 1'b0;
    logic              m_ovf = 1'b0;
    logic              e_en = 1'b0, e_sof = 1'b0, e_eol = 1'b0, e_eof = 1'b0;
    logic [FILL_W-1:0] e_fill = '0;
    logic [W-1:0]      e_data = '0;
    logic              e_data_chk = 1'b0;
    logic [W-1:0]      exp_w;

    in_port_packer #(
        .DSIZE (DSIZE),
        .PSIZE (PSIZE),
        .PACK  (PACK),
        .FILL_W(FILL_W)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .falign   (falign),
        .lalign   (lalign),
        .ealign   (ealign),
        .idata_vld(idata_vld),
        .idata    (idata),
        .fifo_full(fifo_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_sof   (wr_sof),
        .wr_eol   (wr_eol),
        .wr_eof   (wr_eof),
        .wr_fill  (wr_fill),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("wr_en", W'(wr_en), W'(e_en));
        chk("wr_sof", W'(wr_sof), W'(e_sof));
        chk("wr_eol", W'(wr_eol), W'(e_eol));
        chk("wr_eof", W'(wr_eof), W'(e_eof));
        chk("wr_fill", W'(wr_fill), W'(e_fill));
        chk("overflow", W'(overflow), W'(m_ovf));
        if (e_data_chk) chk("wr_data", wr_data, e_data);
    endtask

    // One clock of stimulus; model predicts what the DUT shows after the edge.
    task automatic step(input logic f, input logic l, input logic e, input logic v,
                        input logic [DSIZE-1:0] d, input logic full);
        logic n_ovf;
        logic boundary;
        rst_n = 1'b1; falign = f; lalign = l; ealign = e;
        idata_vld = v; idata = d; fifo_full = full;

        // A write visible now into a full FIFO sets overflow; falign clears it.
        n_ovf = f ? 1'b0 : (m_ovf | (e_en & full));
        if (f) begin
            cur.delete();
            m_sof = 1'b1;
        end
        if (v) cur.push_back(d);
        boundary = !f && (l || e);

        e_en = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_eof = 1'b0; e_fill = '0;
        e_data_chk = 1'b0;
        if (cur.size() == PACK || (boundary && cur.size() > 0)) begin
            e_en   = 1'b1;
            e_data = '0;
            for (int k = 0; k < cur.size(); k++) e_data[k*PSIZE +: PSIZE] = PSIZE'(cur[k]);
            e_fill = FILL_W'(cur.size());
            e_sof  = m_sof;
            e_eol  = boundary;
            e_eof  = boundary && e;
            m_sof  = 1'b0;
            cur.delete();
            e_data_chk = 1'b1;
        end
        m_ovf = n_ovf;

        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; falign = 1'b0; lalign = 1'b1; ealign = 1'b0;
        idata_vld = 1'b1; idata = 24'h123456; fifo_full = 1'b1;
        cur.delete();
        m_sof = 1'b0; m_ovf = 1'b0;
        e_en = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_eof = 1'b0; e_fill = '0;
        e_data = '0; e_data_chk = 1'b1;
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic px(input logic [DSIZE-1:0] d);
        step(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; falign = 1'b0; lalign = 1'b0; ealign = 1'b0;
        idata_vld = 1'b0; idata = '0; fifo_full = 1'b0;

        // Reset, frame start, eight pixels -> two full words
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            px(DSIZE'(i));
            if (i == 4) begin
                exp_w = {32'h4, 32'h3, 32'h2, 32'h1};
                chk("word0_data", wr_data, exp_w);
                chk("word0_sof", W'(wr_sof), W'(1'b1));
                chk("word0_fill", W'(wr_fill), W'(3'd4));
            end
            if (i == 8) begin
                exp_w = {32'h8, 32'h7, 32'h6, 32'h5};
                chk("word1_data", wr_data, exp_w);
                chk("word1_sof", W'(wr_sof), W'(1'b0));
            end
        end

        // Six-pixel line: flush of two pixels with EOL, then next pixel in slot 0
        for (int i = 1; i <= 5; i++) px(DSIZE'(24'h10 + i));
        step(1'b0, 1'b1, 1'b0, 1'b1, 24'h16, 1'b0);
        exp_w = {32'h0, 32'h0, 32'h16, 32'h15};
        chk("eol_data", wr_data, exp_w);
        chk("eol_fill", W'(wr_fill), W'(3'd2));
        chk("eol_flag", W'(wr_eol), W'(1'b1));
        for (int i = 1; i <= 4; i++) px(DSIZE'(24'h20 + i));
        chk("next_slot0", W'(wr_data[PSIZE-1:0]), W'(32'h21));

        // Full line then lalign with no pixel: no extra write
        for (int i = 1; i <= 4; i++) px(DSIZE'(24'h30 + i));
        chk("full_no_eol", W'(wr_eol), W'(1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("empty_lalign", W'(wr_en), W'(1'b0));

        // falign drops a partial word; its own pixel opens the new frame
        for (int i = 1; i <= 3; i++) px(DSIZE'(24'h40 + i));
        step(1'b1, 1'b0, 1'b0, 1'b1, 24'hAAAAAA, 1'b0);
        chk("falign_nowrite", W'(wr_en), W'(1'b0));
        for (int i = 1; i <= 3; i++) px(DSIZE'(24'h50 + i));
        chk("falign_slot0", W'(wr_data[PSIZE-1:0]), W'(32'h00AAAAAA));
        chk("falign_sof", W'(wr_sof), W'(1'b1));

        // Two-pixel frame closed by ealign
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        px(24'h61);
        step(1'b0, 1'b0, 1'b1, 1'b1, 24'h62, 1'b0);
        chk("sf_sof", W'(wr_sof), W'(1'b1));
        chk("sf_eol", W'(wr_eol), W'(1'b1));
        chk("sf_eof", W'(wr_eof), W'(1'b1));
        chk("sf_fill", W'(wr_fill), W'(3'd2));

        // Overflow is sticky until falign; mid-frame reset leaves no flush
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 4; i++) px(DSIZE'(24'h70 + i));
        step(1'b0, 1'b0, 1'b0, 1'b1, 24'h75, 1'b1);
        chk("ovf_set", W'(overflow), W'(1'b1));
        for (int i = 6; i <= 9; i++) px(DSIZE'(24'h70 + i));
        idle();
        chk("ovf_sticky", W'(overflow), W'(1'b1));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("ovf_clr", W'(overflow), W'(1'b0));
        px(24'h81);
        px(24'h82);
        do_reset();
        chk("rst_wr_en", W'(wr_en), W'(1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("rst_no_flush", W'(wr_en), W'(1'b0));

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 99) < 3),
                     ($urandom_range(0, 99) < 10),
                     ($urandom_range(0, 99) < 5),
                     ($urandom_range(0, 99) < 80),
                     DSIZE'($urandom),
                     ($urandom_range(0, 99) < 10));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
